// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of the signals exchanged between the 5-stage datapath/decoder and the
// pipeline hazard controller. master = datapath side, slave = controller.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_rf_le;
    logic             ex_l;
    logic [4:0]       mem_rd;
    logic             mem_rf_le;
    logic [4:0]       wb_rd;
    logic             wb_rf_le;
    logic             ex_redirect;
    logic             ex_annul_ds;
    // mem_req/mem_rdy: the access is pending while mem_req=1; it completes in a
    // cycle where mem_req=1 and mem_rdy=1, and the pipe advances in that cycle.
    logic             mem_req;
    logic             mem_rdy;
    logic             pc_le;
    logic             pc_sel_tgt;
    logic             ifid_le;
    logic             ifid_flush;
    logic             idex_le;
    logic             idex_nop;
    logic             exmem_le;
    logic             memwb_le;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       state_dbg;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_rf_le, ex_l,
               mem_rd, mem_rf_le, wb_rd, wb_rf_le, ex_redirect, ex_annul_ds,
               mem_req, mem_rdy,
        input  pc_le, pc_sel_tgt, ifid_le, ifid_flush, idex_le, idex_nop,
               exmem_le, memwb_le, fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt,
               state_dbg
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_rf_le, ex_l,
               mem_rd, mem_rf_le, wb_rd, wb_rf_le, ex_redirect, ex_annul_ds,
               mem_req, mem_rdy,
        output pc_le, pc_sel_tgt, ifid_le, ifid_flush, idex_le, idex_nop,
               exmem_le, memwb_le, fwd_a, fwd_b, mem_err, stall_cnt, flush_cnt,
               state_dbg
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, branch redirect flushes, memory-wait
// freeze with watchdog, and ID-stage operand forwarding selects.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MWAIT   = 2'd2,
        ST_ERR     = 2'd3
    } state_t;

    state_t           state;
    logic [15:0]      wait_cnt;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic             mem_err_q;

    logic hazard, freeze, is_err, frozen, advance, haz_act, redir_act;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (rs == 5'd0)                                             return 2'b00;
        else if (bus.ex_rf_le && bus.ex_rd == rs && !bus.ex_l)      return 2'b01;
        else if (bus.mem_rf_le && bus.mem_rd == rs)                 return 2'b10;
        else if (bus.wb_rf_le && bus.wb_rd == rs)                   return 2'b11;
        else                                                        return 2'b00;
    endfunction

    always_comb begin
        hazard = bus.ex_l && bus.ex_rf_le && (bus.ex_rd != 5'd0) &&
                 ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                  (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
        freeze = bus.mem_req && !bus.mem_rdy;
        is_err = (state == ST_ERR);
        // Once waiting, only mem_rdy releases the pipe, independent of mem_req.
        frozen    = !is_err && ((state == ST_MWAIT) ? !bus.mem_rdy : freeze);
        advance   = !is_err && !frozen;
        haz_act   = advance && hazard;
        redir_act = advance && !hazard && bus.ex_redirect;
    end

    assign bus.pc_le      = advance && !hazard;
    assign bus.pc_sel_tgt = redir_act;
    assign bus.ifid_le    = advance && !hazard;
    assign bus.ifid_flush = redir_act;
    assign bus.idex_le    = advance;
    assign bus.idex_nop   = haz_act || (redir_act && bus.ex_annul_ds);
    assign bus.exmem_le   = advance;
    assign bus.memwb_le   = advance;
    assign bus.fwd_a      = fwd_sel(bus.id_rs1);
    assign bus.fwd_b      = fwd_sel(bus.id_rs2);
    assign bus.mem_err    = mem_err_q;
    assign bus.stall_cnt  = stall_q;
    assign bus.flush_cnt  = flush_q;
    assign bus.state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            if ((frozen || haz_act) && stall_q != {CNT_W{1'b1}})
                stall_q <= stall_q + CNT_W'(1);
            if (redir_act && flush_q != {CNT_W{1'b1}})
                flush_q <= flush_q + CNT_W'(1);

            case (state)
                ST_RUN: begin
                    if (freeze) begin
                        state    <= ST_MWAIT;
                        wait_cnt <= '0;
                    end else if (hazard) begin
                        state <= ST_LDSTALL;
                    end
                end
                ST_LDSTALL: begin
                    if (freeze) begin
                        state    <= ST_MWAIT;
                        wait_cnt <= '0;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_MWAIT: begin
                    if (bus.mem_rdy) begin
                        state <= ST_RUN;
                    end else if (wait_cnt == 16'(MEM_TIMEOUT - 1)) begin
                        state     <= ST_ERR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= ST_ERR;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl: a table of single-cycle cases
// followed by hand-written multi-cycle sequences (load-use, mem wait, timeout).
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 16;
    localparam logic [7:0] C_NRM = 8'b1010_1011;
    localparam logic [7:0] C_HAZ = 8'b0000_1111;
    localparam logic [7:0] C_RDR = 8'b1111_1011;
    localparam logic [7:0] C_RDA = 8'b1111_1111;
    localparam logic [7:0] C_FRZ = 8'b0000_0000;
    localparam logic [1:0] S_RUN = 2'd0, S_LDS = 2'd1, S_MW = 2'd2, S_ERR = 2'd3;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] ex_rd;
        logic       ex_rf, ex_l;
        logic [4:0] mem_rd;
        logic       mem_rf;
        logic [4:0] wb_rd;
        logic       wb_rf, redir, annul, mreq, mrdy;
        logic [7:0] ctrl;
        logic [1:0] fa, fb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[16];
    vec_t idle, v;
    int   exp_stall, exp_flush;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input vec_t x);
        bus.id_rs1 = x.rs1;        bus.id_rs2 = x.rs2;
        bus.id_use_rs1 = x.u1;     bus.id_use_rs2 = x.u2;
        bus.ex_rd = x.ex_rd;       bus.ex_rf_le = x.ex_rf;   bus.ex_l = x.ex_l;
        bus.mem_rd = x.mem_rd;     bus.mem_rf_le = x.mem_rf;
        bus.wb_rd = x.wb_rd;       bus.wb_rf_le = x.wb_rf;
        bus.ex_redirect = x.redir; bus.ex_annul_ds = x.annul;
        bus.mem_req = x.mreq;      bus.mem_rdy = x.mrdy;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_now();
        return {bus.pc_le, bus.pc_sel_tgt, bus.ifid_le, bus.ifid_flush,
                bus.idex_le, bus.idex_nop, bus.exmem_le, bus.memwb_le};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(idle);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        //          rs1 rs2 u1 u2 exrd exrf exl memrd memrf wbrd wbrf rd an mq my ctrl  fa     fb
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NRM, 2'b00, 2'b00};
        tbl[1]  = '{5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, C_HAZ, 2'b00, 2'b00};
        tbl[2]  = '{5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, C_NRM, 2'b00, 2'b00};
        tbl[3]  = '{0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, C_NRM, 2'b00, 2'b00};
        tbl[4]  = '{0, 3, 0, 1, 3, 1, 0, 3, 1, 0, 0, 0, 0, 0, 1, C_NRM, 2'b00, 2'b01};
        tbl[5]  = '{0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, C_NRM, 2'b00, 2'b00};
        tbl[6]  = '{0, 3, 0, 1, 0, 1, 0, 3, 1, 0, 0, 0, 0, 0, 1, C_NRM, 2'b00, 2'b10};
        tbl[7]  = '{7, 0, 1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 1, C_NRM, 2'b11, 2'b00};
        tbl[8]  = '{7, 7, 1, 1, 0, 0, 0, 7, 1, 7, 1, 0, 0, 0, 1, C_NRM, 2'b10, 2'b10};
        tbl[9]  = '{4, 0, 0, 0, 4, 1, 1, 4, 1, 0, 0, 0, 0, 0, 1, C_NRM, 2'b10, 2'b00};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, C_RDR, 2'b00, 2'b00};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, C_RDA, 2'b00, 2'b00};
        tbl[12] = '{5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, C_HAZ, 2'b00, 2'b00};
        tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, C_FRZ, 2'b00, 2'b00};
        tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NRM, 2'b00, 2'b00};
        tbl[15] = '{5, 0, 1, 0, 5, 0, 0, 0, 0, 5, 1, 0, 0, 0, 1, C_NRM, 2'b11, 2'b00};
        idle = tbl[0];

        // Reset state
        do_reset();
        @(negedge clk);
        chk("reset_ctrl", 32'(ctrl_now()), 32'(C_NRM));
        chk("reset_state", 32'(bus.state_dbg), 32'(S_RUN));
        chk("reset_err", 32'(bus.mem_err), 0);
        chk("reset_stall", 32'(bus.stall_cnt), 0);
        chk("reset_flush", 32'(bus.flush_cnt), 0);
        next_cycle();

        // Table: each vector from RUN, followed by an idle cycle that lets the FSM settle
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_now()), 32'(tbl[i].ctrl));
            chk($sformatf("vec%0d_fwd_a", i), 32'(bus.fwd_a), 32'(tbl[i].fa));
            chk($sformatf("vec%0d_fwd_b", i), 32'(bus.fwd_b), 32'(tbl[i].fb));
            if (tbl[i].ctrl[7] == 1'b0) exp_stall++;
            if (tbl[i].ctrl[6] == 1'b1) exp_flush++;
            next_cycle();
            drive(idle);
            next_cycle();
        end
        @(negedge clk);
        chk("tbl_state", 32'(bus.state_dbg), 32'(S_RUN));
        chk("tbl_stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
        chk("tbl_flush_cnt", 32'(bus.flush_cnt), 32'(exp_flush));

        // Load-use: exactly one bubble, then normal flow
        do_reset();
        drive(tbl[1]);
        @(negedge clk);
        chk("lu_bubble", 32'(ctrl_now()), 32'(C_HAZ));
        next_cycle();
        v = idle; v.rs1 = 5; v.u1 = 1;
        drive(v);
        @(negedge clk);
        chk("lu_state", 32'(bus.state_dbg), 32'(S_LDS));
        chk("lu_after", 32'(ctrl_now()), 32'(C_NRM));
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 1);
        next_cycle();
        @(negedge clk);
        chk("lu_back_run", 32'(bus.state_dbg), 32'(S_RUN));
        next_cycle();

        // Memory wait: 3 frozen cycles, advance on the 4th
        do_reset();
        v = idle; v.mreq = 1; v.mrdy = 0;
        drive(v);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mw_frozen%0d", k), 32'(ctrl_now()), 32'(C_FRZ));
            if (k > 0) chk($sformatf("mw_state%0d", k), 32'(bus.state_dbg), 32'(S_MW));
            next_cycle();
        end
        v.mrdy = 1;
        drive(v);
        @(negedge clk);
        chk("mw_release", 32'(ctrl_now()), 32'(C_NRM));
        next_cycle();
        drive(idle);
        @(negedge clk);
        chk("mw_state_run", 32'(bus.state_dbg), 32'(S_RUN));
        chk("mw_stall_cnt", 32'(bus.stall_cnt), 3);
        next_cycle();

        // Redirect deferred behind a freeze, taken in the mem_rdy cycle
        do_reset();
        v = idle; v.mreq = 1; v.mrdy = 0; v.redir = 1;
        drive(v);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("rf_held%0d", k), 32'(ctrl_now()), 32'(C_FRZ));
            next_cycle();
        end
        v.mrdy = 1;
        drive(v);
        @(negedge clk);
        chk("rf_redirect", 32'(ctrl_now()), 32'(C_RDR));
        next_cycle();
        drive(idle);
        @(negedge clk);
        chk("rf_flush_cnt", 32'(bus.flush_cnt), 1);
        chk("rf_stall_cnt", 32'(bus.stall_cnt), 2);
        next_cycle();

        // Watchdog with MEM_TIMEOUT=4: RUN freeze cycle + 4 MWAIT cycles, then ERR
        do_reset();
        v = idle; v.mreq = 1; v.mrdy = 0;
        drive(v);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) begin
                chk("to_last_wait_state", 32'(bus.state_dbg), 32'(S_MW));
                chk("to_last_wait_err", 32'(bus.mem_err), 0);
            end
            next_cycle();
        end
        @(negedge clk);
        chk("to_state_err", 32'(bus.state_dbg), 32'(S_ERR));
        chk("to_mem_err", 32'(bus.mem_err), 1);
        chk("to_ctrl", 32'(ctrl_now()), 32'(C_FRZ));
        next_cycle();
        v.mrdy = 1;
        drive(v);
        @(negedge clk);
        chk("to_absorbing", 32'(bus.state_dbg), 32'(S_ERR));
        chk("to_ctrl_rdy", 32'(ctrl_now()), 32'(C_FRZ));
        // Asynchronous reset, sampled before any clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("ar_state", 32'(bus.state_dbg), 32'(S_RUN));
        chk("ar_mem_err", 32'(bus.mem_err), 0);
        chk("ar_stall", 32'(bus.stall_cnt), 0);
        chk("ar_flush", 32'(bus.flush_cnt), 0);
        drive(idle);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_ctrl", 32'(ctrl_now()), 32'(C_NRM));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
